axis2fifo_result: RTL and testbench
===================================

# axis2fifo_result

Result-side companion to the accelerator input stage. It is the AXI-Stream slave that receives output packets from the HLS accelerator and buffers them in a circular FIFO for the host/testbench read side. It handles one packet at a time, reports packet completion and length, and back-pressures the accelerator until each packet has been drained.

## Interface
- DATA_WIDTH, 32, width of stream and FIFO words
- DEPTH, 8, FIFO depth in words; power of two, ≥2; AW = log2(DEPTH)
- MAX_PKT, 16, maximum beats per packet before forced termination; 1..65535
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- m_axis_tdata  in  DATA_WIDTH  accelerator result word
- m_axis_tvalid  in  1  accelerator beat valid
- m_axis_tlast  in  1  last beat of packet
- m_axis_tready  out  1  this block accepts beat
- fifo_rd_en  in  1  read request
- fifo_rd_data  out  DATA_WIDTH  read word, registered
- fifo_rd_valid  out  1  fifo_rd_data valid this cycle
- fifo_empty  out  1  no words stored
- fifo_full  out  1  DEPTH words stored
- fifo_count  out  AW+1  words stored, 0..DEPTH
- pkt_done  out  1  one-cycle pulse on packet end
- pkt_len  out  16  beat count of last completed packet
- len_err  out  1  sticky: packet hit MAX_PKT without tlast

## Operation
- Beat accepted iff m_axis_tvalid && m_axis_tready, on that clock edge; the word is written at wr_ptr, wr_ptr increments modulo DEPTH.
- m_axis_tready = (state != DONE) && !fifo_full, decoded from registered state and count only; never depends on tvalid.
- FSM:
  - IDLE: waiting for first beat. Accepted beat without tlast → RECV, beat_cnt = 1. Accepted beat with tlast → DONE, pkt_done, pkt_len = 1.
  - RECV: each accepted beat increments beat_cnt. On an accepted tlast beat → DONE, pkt_done, pkt_len = beat_cnt+1. On an accepted non-tlast beat when beat_cnt+1 == MAX_PKT → DONE, pkt_done, pkt_len = MAX_PKT, len_err set.
  - DONE: tready low. → IDLE on the first cycle fifo_empty is 1 (not including the cycle of entry if already empty; see Timing).
  - Default/illegal encoding → IDLE.
- Read: fifo_rd_en && !fifo_empty → fifo_rd_data <= mem[rd_ptr], fifo_rd_valid <= 1, rd_ptr increments modulo DEPTH. Otherwise fifo_rd_valid <= 0 and fifo_rd_data holds.
- Read when empty is ignored: no pointer or count change, and no error.
- Simultaneous accepted write and valid read: count unchanged and both pointers advance. Write-only: count +1. Read-only: count −1.
- A full FIFO in RECV stalls via tready; no data is ever dropped.
- Beats arriving in DONE are not accepted; the accelerator holds them per AXI-Stream rules.
- len_err is cleared only by reset. beat_cnt is cleared on entry to IDLE.

## Timing
- Reset (rst_n low at an edge): state IDLE, pointers 0, count 0. Outputs: m_axis_tready 0 during reset and 1 on the first cycle after release; fifo_rd_data 0, fifo_rd_valid 0, fifo_empty 1, fifo_full 0, fifo_count 0, pkt_done 0, pkt_len 0, len_err 0.
- Reset mid-packet discards all stored data and partial counts. There is no recovery of the interrupted packet.
- Write latency: a word accepted at edge N is visible in fifo_count and fifo_empty after edge N and is readable via fifo_rd_en from cycle N+1.
- Read latency: fifo_rd_en sampled at edge N → fifo_rd_data/fifo_rd_valid valid after edge N, for one cycle.
- pkt_done: high for exactly the one cycle following the edge that accepted the terminating beat; pkt_len updates on the same edge.
- DONE exit: DONE is entered at edge N. The DONE→IDLE transition occurs at the first edge M>N with fifo_count==0 sampled, so tready rises at the earliest one cycle after the FIFO empties. Minimum DONE dwell is 1 cycle.
- fifo_full/fifo_empty/fifo_count are registered and mutually consistent every cycle.

## Test plan
- Reset release, no stimulus → tready 1 from cycle 1, fifo_empty 1, fifo_count 0, all other outputs 0.
- Packet 0x11,0x22,0x33,0x44 (tlast on 0x44), tvalid continuous → 4 beats accepted in 4 cycles; pkt_done one cycle with pkt_len 4; tready 0. Reading 4 times returns 0x11..0x44 in order. tready returns to 1 one cycle after fifo_count hits 0.
- DEPTH=8, 10-beat packet, no reads → tready drops after 8 beats, fifo_full 1. Reading 2 words lets beats 9 and 10 in; pkt_len 10.
- Continuous stream read every cycle starting one cycle after the first write → fifo_count stays at 1 and never reaches full. Data order is preserved across pointer wrap (≥3×DEPTH beats).
- MAX_PKT=16, 20 beats and no tlast → 16 accepted, pkt_done with pkt_len 16, len_err 1 and sticky through the next clean packet.
- rst_n low mid-packet after 3 beats → count 0, empty 1, pkt_len 0. The next 2-beat packet reads back only its own 2 words.

Source files
------------

// File: rtl/axis2fifo_result_if.sv
// AXI-Stream result channel from the accelerator into the result FIFO.
interface axis2fifo_result_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tlast;
    logic                  m_axis_tready;

    // Accelerator side drives the beat, receives ready.
    modport master (
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast,
        input  m_axis_tready
    );

    // Result buffer side consumes the beat, drives ready.
    modport slave (
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/axis2fifo_result.sv
// Result-side AXI-Stream slave: buffers one accelerator packet at a time in a
// circular FIFO, reports completion/length, and holds off the accelerator
// until the host has drained the packet.
module axis2fifo_result #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int MAX_PKT    = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axis2fifo_result_if.slave     axis,
    input  logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_valid,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic [AW:0]           fifo_count,
    output logic                  pkt_done,
    output logic [15:0]           pkt_len,
    output logic                  len_err
);

    localparam logic [AW:0]  DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [15:0]  MAX_LEN   = 16'(MAX_PKT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [15:0]           beat_cnt;
    logic [15:0]           beat_inc;
    logic [AW:0]           count_nxt;
    logic                  wr_fire;
    logic                  rd_fire;

    // Ready comes only from registered state/occupancy; held low while in reset.
    assign axis.m_axis_tready = rst_n && (state != DONE) && !fifo_full;

    assign wr_fire  = axis.m_axis_tvalid && axis.m_axis_tready;
    assign rd_fire  = fifo_rd_en && !fifo_empty;
    assign beat_inc = beat_cnt + 16'd1;

    // Occupancy after this edge; simultaneous write+read leaves it unchanged.
    always_comb begin
        count_nxt = fifo_count;
        case ({wr_fire, rd_fire})
            2'b10:   count_nxt = fifo_count + 1'b1;
            2'b01:   count_nxt = fifo_count - 1'b1;
            default: count_nxt = fifo_count;
        endcase
    end

    // Storage array; writes only happen out of reset since ready is gated.
    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[wr_ptr] <= axis.m_axis_tdata;
    end

    // Pointers, registered read port and registered occupancy flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            fifo_empty    <= 1'b1;
            fifo_full     <= 1'b0;
            fifo_rd_valid <= 1'b0;
            fifo_rd_data  <= '0;
        end else begin
            if (wr_fire)
                wr_ptr <= wr_ptr + 1'b1;
            fifo_rd_valid <= rd_fire;
            if (rd_fire) begin
                fifo_rd_data <= mem[rd_ptr];
                rd_ptr       <= rd_ptr + 1'b1;
            end
            fifo_count <= count_nxt;
            fifo_empty <= (count_nxt == '0);
            fifo_full  <= (count_nxt == DEPTH_CNT);
        end
    end

    // Packet FSM: counts beats, terminates on tlast or length limit, and
    // parks in DONE until the FIFO has been fully drained.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
            pkt_done <= 1'b0;
            pkt_len  <= '0;
            len_err  <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_fire) begin
                        if (axis.m_axis_tlast) begin
                            state    <= DONE;
                            pkt_done <= 1'b1;
                            pkt_len  <= 16'd1;
                        end else if (MAX_PKT == 1) begin
                            // A single-beat limit cuts the packet on its first beat.
                            state    <= DONE;
                            pkt_done <= 1'b1;
                            pkt_len  <= 16'd1;
                            len_err  <= 1'b1;
                        end else begin
                            state    <= RECV;
                            beat_cnt <= 16'd1;
                        end
                    end
                end
                RECV: begin
                    if (wr_fire) begin
                        if (axis.m_axis_tlast) begin
                            state    <= DONE;
                            pkt_done <= 1'b1;
                            pkt_len  <= beat_inc;
                        end else if (beat_inc == MAX_LEN) begin
                            state    <= DONE;
                            pkt_done <= 1'b1;
                            pkt_len  <= MAX_LEN;
                            len_err  <= 1'b1;
                        end else begin
                            beat_cnt <= beat_inc;
                        end
                    end
                end
                DONE: begin
                    // fifo_empty is registered, so the entry edge never sees
                    // an exit; the earliest exit is the following edge.
                    if (fifo_empty) begin
                        state    <= IDLE;
                        beat_cnt <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis2fifo_result.sv
// Directed + randomized bench for axis2fifo_result against a queue-based
// packet model.
module tb_axis2fifo_result;

    localparam int DW      = 32;
    localparam int DEPTH   = 8;
    localparam int MAX_PKT = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_valid;
    logic          fifo_empty;
    logic          fifo_full;
    logic [3:0]    fifo_count;
    logic          pkt_done;
    logic [15:0]   pkt_len;
    logic          len_err;

    axis2fifo_result_if #(.DATA_WIDTH(DW)) bif ();

    axis2fifo_result #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .MAX_PKT   (MAX_PKT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .axis         (bif),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_valid(fifo_rd_valid),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .fifo_count   (fifo_count),
        .pkt_done     (pkt_done),
        .pkt_len      (pkt_len),
        .len_err      (len_err)
    );

    always #5 clk = ~clk;

    // Reference model: stored words, whether a finished packet is awaiting
    // drain, and the beats of the packet in progress.
    logic [DW-1:0] q[$];
    logic [DW-1:0] got[$];
    bit            m_done;
    int            beats;
    logic          e_done;
    logic [15:0]   e_len;
    logic          e_err;
    logic          e_rdv;
    logic [DW-1:0] e_rdd;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_done = 0;
        beats  = 0;
        e_done = 0;
        e_len  = '0;
        e_err  = 0;
        e_rdv  = 0;
        e_rdd  = '0;
    endtask

    task automatic compare_all(input string ph);
        chk({ph, ":count"},    32'(fifo_count), q.size());
        chk({ph, ":empty"},    32'(fifo_empty), 32'(q.size() == 0));
        chk({ph, ":full"},     32'(fifo_full),  32'(q.size() == DEPTH));
        chk({ph, ":rd_valid"}, 32'(fifo_rd_valid), 32'(e_rdv));
        chk({ph, ":rd_data"},  fifo_rd_data, e_rdd);
        chk({ph, ":pkt_done"}, 32'(pkt_done), 32'(e_done));
        chk({ph, ":pkt_len"},  32'(pkt_len),  32'(e_len));
        chk({ph, ":len_err"},  32'(len_err),  32'(e_err));
    endtask

    // One clock: drive inputs, predict, clock, then compare away from the edge.
    task automatic step(input string ph, input logic v, input logic [DW-1:0] d,
                        input logic l, input logic r, output logic acc);
        int   sz0;
        logic rdy;
        logic rd;
        bif.m_axis_tvalid = v;
        bif.m_axis_tdata  = d;
        bif.m_axis_tlast  = l;
        fifo_rd_en        = r;
        sz0 = q.size();
        rdy = !m_done && (sz0 < DEPTH);
        acc = v && rdy;
        rd  = r && (sz0 > 0);
        #1;
        chk({ph, ":tready"}, 32'(bif.m_axis_tready), 32'(rdy));
        @(posedge clk);
        if (rd) e_rdd = q.pop_front();
        e_rdv  = rd;
        e_done = 0;
        if (m_done && sz0 == 0) m_done = 0;
        if (acc) begin
            q.push_back(d);
            beats++;
            if (l || beats == MAX_PKT) begin
                e_done = 1;
                e_len  = 16'(beats);
                if (!l) e_err = 1;
                m_done = 1;
                beats  = 0;
            end
        end
        #1;
        compare_all(ph);
        if (fifo_rd_valid) got.push_back(fifo_rd_data);
    endtask

    task automatic send_beat(input string ph, input logic [DW-1:0] d, input logic l,
                             input logic r);
        logic acc;
        int   tries;
        tries = 0;
        do begin
            step(ph, 1'b1, d, l, r, acc);
            tries++;
        end while (!acc && tries < 40);
        if (!acc) chk({ph, ":send_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic drain(input string ph);
        logic acc;
        int   n;
        n = 0;
        while ((q.size() != 0 || m_done) && n < 64) begin
            step(ph, 1'b0, '0, 1'b0, 1'b1, acc);
            n++;
        end
        if (q.size() != 0 || m_done) chk({ph, ":drain_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset(input string ph);
        rst_n             = 1'b0;
        bif.m_axis_tvalid = 1'b0;
        bif.m_axis_tdata  = '0;
        bif.m_axis_tlast  = 1'b0;
        fifo_rd_en        = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
        chk({ph, ":tready_in_reset"}, 32'(bif.m_axis_tready), 32'd0);
        compare_all(ph);
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    logic        acc;
    int          acc_cnt;
    int          stuck;
    int          max_cnt;
    bit          saw_full;
    logic [31:0] w;

    initial begin
        // Reset and quiet cycles.
        do_reset("reset");
        for (int i = 0; i < 3; i++) step("idle", 1'b0, '0, 1'b0, 1'b0, acc);

        // Four-beat packet with continuous tvalid, then read back.
        for (int i = 0; i < 4; i++) begin
            w = 32'h11 * (i + 1);
            send_beat("pkt4", w, i == 3, 1'b0);
        end
        chk("pkt4:len", 32'(pkt_len), 32'd4);
        chk("pkt4:done", 32'(pkt_done), 32'd1);
        got.delete();
        drain("pkt4_rd");
        chk("pkt4:nread", got.size(), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk("pkt4:data", got[i], 32'h11 * (i + 1));

        // Ten-beat packet overflowing an 8-deep FIFO; reads release the stall.
        saw_full = 0;
        for (int i = 0; i < 10; i++) begin
            stuck = 0;
            do begin
                step("pkt10", 1'b1, 32'hA000 + i, i == 9, stuck >= 3, acc);
                if (fifo_full) saw_full = 1;
                stuck++;
            end while (!acc && stuck < 40);
        end
        chk("pkt10:saw_full", 32'(saw_full), 32'd1);
        chk("pkt10:len", 32'(pkt_len), 32'd10);
        drain("pkt10_rd");

        // Streaming with a read every cycle after the first write, across wrap.
        max_cnt = 0;
        step("stream", 1'b1, $urandom, 1'b0, 1'b0, acc);
        for (int p = 0; p < 4; p++) begin
            for (int i = (p == 0) ? 1 : 0; i < 8; i++) begin
                send_beat("stream", $urandom, i == 7, 1'b1);
                if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            end
        end
        chk("stream:max_count", max_cnt, 32'd1);
        drain("stream_rd");

        // No tlast: length limit forces termination at MAX_PKT.
        acc_cnt = 0;
        for (int i = 0; i < 40 && acc_cnt < MAX_PKT; i++) begin
            step("maxpkt", 1'b1, $urandom, 1'b0, i > 0, acc);
            if (acc) acc_cnt++;
        end
        step("maxpkt_held", 1'b1, $urandom, 1'b0, 1'b1, acc);
        chk("maxpkt:held_not_taken", 32'(acc), 32'd0);
        chk("maxpkt:accepted", acc_cnt, MAX_PKT);
        chk("maxpkt:len", 32'(pkt_len), MAX_PKT);
        chk("maxpkt:len_err", 32'(len_err), 32'd1);
        drain("maxpkt_rd");
        for (int i = 0; i < 3; i++) send_beat("clean", $urandom, i == 2, 1'b0);
        drain("clean_rd");
        chk("clean:len", 32'(pkt_len), 32'd3);
        chk("clean:len_err_sticky", 32'(len_err), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step("random", $urandom_range(0, 3) != 0, $urandom,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, acc);
        drain("random_rd");

        // Reset in the middle of a packet discards it.
        for (int i = 0; i < 3; i++) send_beat("midrst", 32'hDEAD0 + i, 1'b0, 1'b0);
        do_reset("midrst_reset");
        chk("midrst:count", 32'(fifo_count), 32'd0);
        chk("midrst:pkt_len", 32'(pkt_len), 32'd0);
        send_beat("after_rst", 32'hBEEF1, 1'b0, 1'b0);
        send_beat("after_rst", 32'hBEEF2, 1'b1, 1'b0);
        got.delete();
        drain("after_rst_rd");
        chk("after_rst:nread", got.size(), 32'd2);
        if (got.size() == 2) begin
            chk("after_rst:data0", got[0], 32'hBEEF1);
            chk("after_rst:data1", got[1], 32'hBEEF2);
        end
        chk("after_rst:len", 32'(pkt_len), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
